// File: rtl/alu_serial_pkg.sv
// Shared types and constants for the bit-serial ALU sequencer.
// Control field positions and op codes describe the 4-bit ctrl word.
package alu_serial_pkg;

    parameter int unsigned DefaultWidth = 32;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StCmp,
        StDone
    } state_e;

    localparam int unsigned CtrlAInv = 3;
    localparam int unsigned CtrlBInv = 2;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_SET = 2'b11;

endpackage

// File: rtl/alu_serial_decode.sv
// Combinational decode of the control word and sequencer state into
// slice inversion/op controls and the carry seeded at operation start.
module alu_serial_decode
    import alu_serial_pkg::*;
(
    input  state_e     state_i,
    input  logic [3:0] ctrl_i,
    output logic       a_inv_o,
    output logic       b_inv_o,
    output logic [1:0] op_o,
    output logic       init_carry_o
);

    always_comb begin
        a_inv_o      = 1'b0;
        b_inv_o      = 1'b0;
        op_o         = OP_AND;
        init_carry_o = ctrl_i[CtrlBInv];
        unique case (state_i)
            StRun: begin
                a_inv_o = ctrl_i[CtrlAInv];
                b_inv_o = ctrl_i[CtrlBInv];
                // SET runs the bit loop as a subtraction; the compare happens in CMP.
                op_o    = (ctrl_i[1:0] == OP_SET) ? OP_ADD : ctrl_i[1:0];
            end
            StCmp:   op_o = OP_SET;
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_serial_seq.sv
// Bit-serial sequencer driving one external 1-bit ALU slice, LSB first,
// with a start/done handshake towards the datapath.
module alu_serial_seq
    import alu_serial_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    input  logic [3:0]       ctrl_i,
    input  logic [2:0]       comp_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             cout_o,
    output logic             overflow_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             sl_src1_o,
    output logic             sl_src2_o,
    output logic             sl_less_o,
    output logic             sl_equal_o,
    output logic             sl_a_inv_o,
    output logic             sl_b_inv_o,
    output logic             sl_cin_o,
    output logic [1:0]       sl_op_o,
    output logic [2:0]       sl_comp_o,
    input  logic             sl_result_i,
    input  logic             sl_cout_i
);

    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] src1_q, src2_q, res_q, res_d;
    logic [3:0]       ctrl_q, ctrl_dec;
    logic [2:0]       comp_q;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             carry_q, carry_d, cin_msb_q, cin_msb_d;
    logic             zero_q, zero_d, cout_q, cout_d, ovf_q, ovf_d;
    logic             accept, init_carry;

    assign accept   = start_i && (state_q == StIdle || state_q == StDone);
    assign ctrl_dec = busy_o ? ctrl_q : ctrl_i;

    alu_serial_decode u_decode (
        .state_i      (state_q),
        .ctrl_i       (ctrl_dec),
        .a_inv_o      (sl_a_inv_o),
        .b_inv_o      (sl_b_inv_o),
        .op_o         (sl_op_o),
        .init_carry_o (init_carry)
    );

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (start_i) state_d = StRun;
            StRun: begin
                if (cnt_q == LastBit) begin
                    state_d = (ctrl_q[1:0] == OP_SET) ? StCmp : StDone;
                end
            end
            StCmp:   state_d = StDone;
            StDone:  state_d = start_i ? StRun : StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy_o     = (state_q == StRun) || (state_q == StCmp);
        done_o     = (state_q == StDone);
        sl_src1_o  = 1'b0;
        sl_src2_o  = 1'b0;
        sl_cin_o   = 1'b0;
        sl_less_o  = 1'b0;
        sl_equal_o = 1'b0;
        sl_comp_o  = 3'b000;
        if (state_q == StRun) begin
            sl_src1_o = src1_q[cnt_q];
            sl_src2_o = src2_q[cnt_q];
            sl_cin_o  = carry_q;
        end
        if (state_q == StCmp) begin
            // Signed less-than: sign of the difference corrected by overflow.
            sl_less_o  = res_q[WIDTH-1] ^ cin_msb_q ^ carry_q;
            sl_equal_o = ~|res_q;
            sl_comp_o  = comp_q;
        end
    end

    always_comb begin
        res_d     = res_q;
        cnt_d     = cnt_q;
        carry_d   = carry_q;
        cin_msb_d = cin_msb_q;
        zero_d    = zero_q;
        cout_d    = cout_q;
        ovf_d     = ovf_q;
        if (accept) begin
            cnt_d   = '0;
            carry_d = init_carry;
        end else if (state_q == StRun) begin
            res_d[cnt_q] = sl_result_i;
            carry_d      = sl_cout_i;
            cnt_d        = cnt_q + 1'b1;
            if (cnt_q == LastBit) cin_msb_d = carry_q;
        end else if (state_q == StCmp) begin
            res_d = {{(WIDTH-1){1'b0}}, sl_result_i};
        end
        if (state_d == StDone && state_q != StDone) begin
            zero_d = ~|res_d;
            cout_d = ctrl_q[1] & carry_d;
            ovf_d  = (ctrl_q[1:0] == OP_ADD) & (cin_msb_d ^ carry_d);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            src1_q    <= '0;
            src2_q    <= '0;
            ctrl_q    <= '0;
            comp_q    <= '0;
            res_q     <= '0;
            cnt_q     <= '0;
            carry_q   <= 1'b0;
            cin_msb_q <= 1'b0;
            zero_q    <= 1'b0;
            cout_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            if (accept) begin
                src1_q <= src1_i;
                src2_q <= src2_i;
                ctrl_q <= ctrl_i;
                comp_q <= comp_i;
            end
            res_q     <= res_d;
            cnt_q     <= cnt_d;
            carry_q   <= carry_d;
            cin_msb_q <= cin_msb_d;
            zero_q    <= zero_d;
            cout_q    <= cout_d;
            ovf_q     <= ovf_d;
        end
    end

    assign result_o   = res_q;
    assign zero_o     = zero_q;
    assign cout_o     = cout_q;
    assign overflow_o = ovf_q;

endmodule

// File: tb/tb_alu_serial_seq.sv
// Directed bench for alu_serial_seq with a behavioural 1-bit slice model.
module tb_alu_serial_seq;

    localparam logic [2:0] CmpLt = 3'b000;
    localparam logic [2:0] CmpEq = 3'b001;

    typedef struct {
        logic [31:0] s1;
        logic [31:0] s2;
        logic [3:0]  ctrl;
        logic [2:0]  comp;
        logic [31:0] res;
        logic        z;
        logic        c;
        logic        v;
        int          lat;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_i;
    logic [31:0] src1_i, src2_i, result_o;
    logic [3:0]  ctrl_i;
    logic [2:0]  comp_i;
    logic        zero_o, cout_o, overflow_o, busy_o, done_o;
    logic        sl_src1, sl_src2, sl_less, sl_equal, sl_a_inv, sl_b_inv, sl_cin;
    logic [1:0]  sl_op;
    logic [2:0]  sl_comp;
    logic        sl_result, sl_cout;

    int checks = 0;
    int errors = 0;
    vec_t vecs[10];

    always #5 clk = ~clk;

    alu_serial_seq #(.WIDTH(32)) dut (
        .clk_i       (clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .src1_i      (src1_i),
        .src2_i      (src2_i),
        .ctrl_i      (ctrl_i),
        .comp_i      (comp_i),
        .result_o    (result_o),
        .zero_o      (zero_o),
        .cout_o      (cout_o),
        .overflow_o  (overflow_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .sl_src1_o   (sl_src1),
        .sl_src2_o   (sl_src2),
        .sl_less_o   (sl_less),
        .sl_equal_o  (sl_equal),
        .sl_a_inv_o  (sl_a_inv),
        .sl_b_inv_o  (sl_b_inv),
        .sl_cin_o    (sl_cin),
        .sl_op_o     (sl_op),
        .sl_comp_o   (sl_comp),
        .sl_result_i (sl_result),
        .sl_cout_i   (sl_cout)
    );

    // Behavioural 1-bit ALU slice.
    logic sa, sb;
    always_comb begin
        sa      = sl_src1 ^ sl_a_inv;
        sb      = sl_src2 ^ sl_b_inv;
        sl_cout = (sa & sb) | (sa & sl_cin) | (sb & sl_cin);
        case (sl_op)
            2'b00:   sl_result = sa & sb;
            2'b01:   sl_result = sa | sb;
            2'b10:   sl_result = sa ^ sb ^ sl_cin;
            default: begin
                case (sl_comp)
                    CmpLt:   sl_result = sl_less;
                    CmpEq:   sl_result = sl_equal;
                    3'b010:  sl_result = sl_less | sl_equal;
                    3'b011:  sl_result = ~sl_equal;
                    3'b100:  sl_result = ~sl_less & ~sl_equal;
                    default: sl_result = ~sl_less;
                endcase
            end
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic start_op(input logic [31:0] s1, input logic [31:0] s2,
                            input logic [3:0] ctrl, input logic [2:0] comp);
        @(negedge clk);
        src1_i  = s1;
        src2_i  = s2;
        ctrl_i  = ctrl;
        comp_i  = comp;
        start_i = 1'b1;
    endtask

    // Counts edges from the accepting edge until done_o is seen (bounded).
    task automatic wait_done(input bit inject, output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            #1;
            if (lat == 1) start_i = 1'b0;
            if (inject && lat == 5) begin
                start_i = 1'b1;
                src1_i  = 32'hAAAA_AAAA;
                src2_i  = 32'h5555_5555;
                ctrl_i  = 4'b0001;
            end
            if (inject && lat == 6) start_i = 1'b0;
        end while (!done_o && lat < 100);
    endtask

    task automatic check_op(input vec_t v, input int lat, input string tag);
        check($sformatf("%s latency", tag), lat, v.lat);
        check($sformatf("%s result", tag), result_o, v.res);
        check($sformatf("%s zero", tag), {31'd0, zero_o}, {31'd0, v.z});
        check($sformatf("%s cout", tag), {31'd0, cout_o}, {31'd0, v.c});
        check($sformatf("%s overflow", tag), {31'd0, overflow_o}, {31'd0, v.v});
    endtask

    initial begin
        int   lat;
        bit   seen;
        vec_t va, vb;

        rst_n   = 1'b0;
        start_i = 1'b0;
        src1_i  = '0;
        src2_i  = '0;
        ctrl_i  = '0;
        comp_i  = '0;

        vecs[0] = '{32'h7FFF_FFFF, 32'h0000_0001, 4'b0010, 3'd0, 32'h8000_0000, 0, 0, 1, 33};
        vecs[1] = '{32'h0000_0005, 32'h0000_0005, 4'b0110, 3'd0, 32'h0000_0000, 1, 1, 0, 33};
        vecs[2] = '{32'hF0F0_F0F0, 32'h0F0F_0F0F, 4'b1100, 3'd0, 32'h0000_0000, 1, 0, 0, 33};
        vecs[3] = '{32'hFFFF_FFFF, 32'h0000_0001, 4'b0111, CmpLt, 32'h0000_0001, 0, 1, 0, 34};
        vecs[4] = '{32'h0000_0001, 32'hFFFF_FFFF, 4'b0111, CmpLt, 32'h0000_0000, 1, 0, 0, 34};
        vecs[5] = '{32'h8000_0000, 32'h0000_0001, 4'b0111, CmpLt, 32'h0000_0001, 0, 1, 0, 34};
        vecs[6] = '{32'h0000_0005, 32'h0000_0005, 4'b0111, CmpEq, 32'h0000_0001, 0, 1, 0, 34};
        vecs[7] = '{32'hFF00_FF00, 32'h0FF0_0FF0, 4'b0000, 3'd0, 32'h0F00_0F00, 0, 0, 0, 33};
        vecs[8] = '{32'h1234_0000, 32'h0000_5678, 4'b0001, 3'd0, 32'h1234_5678, 0, 0, 0, 33};
        vecs[9] = '{32'hFFFF_FFFF, 32'h0000_0001, 4'b0010, 3'd0, 32'h0000_0000, 1, 1, 0, 33};

        #3;
        check("reset result", result_o, 32'd0);
        check("reset flags", {27'd0, zero_o, cout_o, overflow_o, busy_o, done_o}, 32'd0);
        check("reset slice bus", {20'd0, sl_src1, sl_src2, sl_less, sl_equal, sl_a_inv,
              sl_b_inv, sl_cin, sl_op, sl_comp}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            start_op(vecs[i].s1, vecs[i].s2, vecs[i].ctrl, vecs[i].comp);
            wait_done(1'b0, lat);
            check_op(vecs[i], lat, $sformatf("vec%0d", i));
            @(posedge clk);
            #1;
            check($sformatf("vec%0d done pulse", i), {31'd0, done_o}, 32'd0);
            check($sformatf("vec%0d held result", i), result_o, vecs[i].res);
        end

        // Reset while bit 10 of an ADD is in flight.
        start_op(32'h0000_1234, 32'h0000_0001, 4'b0010, 3'd0);
        lat = 0;
        repeat (11) begin
            @(posedge clk);
            lat++;
            #1;
            start_i = 1'b0;
        end
        check("midrun busy", {31'd0, busy_o}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("abort result", result_o, 32'd0);
        check("abort flags", {27'd0, zero_o, cout_o, overflow_o, busy_o, done_o}, 32'd0);
        check("abort slice bus", {20'd0, sl_src1, sl_src2, sl_less, sl_equal, sl_a_inv,
              sl_b_inv, sl_cin, sl_op, sl_comp}, 32'd0);
        seen = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (done_o) seen = 1'b1;
        end
        check("abort no done", {31'd0, seen}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        va = '{32'd3, 32'd4, 4'b0010, 3'd0, 32'd7, 0, 0, 0, 33};
        start_op(va.s1, va.s2, va.ctrl, va.comp);
        wait_done(1'b0, lat);
        check_op(va, lat, "post-reset add");

        // Start pulsed mid-RUN with different operands must be ignored.
        va = '{32'h64, 32'h17, 4'b0010, 3'd0, 32'h7B, 0, 0, 0, 33};
        start_op(va.s1, va.s2, va.ctrl, va.comp);
        wait_done(1'b1, lat);
        check_op(va, lat, "ignored start");

        // Back-to-back: start issued in the DONE cycle.
        @(posedge clk);
        va = '{32'd10, 32'd3, 4'b0110, 3'd0, 32'd7, 0, 1, 0, 33};
        vb = '{32'h1234_0000, 32'h0000_5678, 4'b0001, 3'd0, 32'h1234_5678, 0, 0, 0, 33};
        start_op(va.s1, va.s2, va.ctrl, va.comp);
        wait_done(1'b0, lat);
        check_op(va, lat, "b2b first");
        src1_i  = vb.s1;
        src2_i  = vb.s2;
        ctrl_i  = vb.ctrl;
        comp_i  = vb.comp;
        start_i = 1'b1;
        wait_done(1'b0, lat);
        check_op(vb, lat, "b2b second");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
